// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets inside the 16-byte window, STATUS bit
// positions and the transmit FSM state encoding.
package mmio_uart_tx_pkg;

  // Word offsets (mem_addr[3:0]); anything else in the window is reserved.
  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_BAUDDIV = 4'h8;

  // STATUS layout: {22'b0, count[5:0], ovf, busy, empty, full}
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART register block.
// Handshake: mem_we / mem_re are single-cycle strobes qualified by
// mem_addr; there is no ready/wait - every store is consumed at the rising
// edge it is presented on and every load is answered combinationally in
// the same cycle. sel and mem_rdata are combinational outputs of the slave.
//   mem_addr  : byte address        mem_wdata : store data
//   mem_we    : store strobe        mem_re    : load strobe
//   sel       : address hits window mem_rdata : load data (0 if not selected)
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        sel;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  sel, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output sel, mem_rdata
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Circular-buffer FIFO used as the UART transmit queue.
// Ports: clk/rst (async active-low), push/din write side, pop/dout read
// side (dout shows the head combinationally), full/empty flags and an
// occupancy count 0..DEPTH. A push while full is accepted only when a pop
// happens in the same cycle; in that case the count is unchanged.
module sync_fifo
  import mmio_uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory bus.
// Ports: clk, rst (async active-low), bus (slave side of mmio_uart_tx_if),
// tx (serial line, idles high), irq (FIFO empty and FSM idle),
// state_dbg_o (current transmit FSM state).
// Registers: TXDATA (push byte), STATUS (count/ovf/busy/empty/full, any
// write clears ovf), BAUDDIV (cycles per bit, 0 stored as 1).
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          DEFAULT_DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 irq,
  output uart_state_t          state_dbg_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // ---------------- register decode ----------------
  logic        sel_w;
  logic [3:0]  off;
  logic        wr_txdata, wr_status, wr_baud;
  logic        push, pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0] baud_q, baud_d;
  logic        ovf_q, ovf_d;
  logic        busy;
  logic [31:0] status_w;
  logic        unused_ok;

  assign sel_w     = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = bus.mem_addr[3:0];
  assign wr_txdata = sel_w & bus.mem_we & (off == UART_TXDATA);
  assign wr_status = sel_w & bus.mem_we & (off == UART_STATUS);
  assign wr_baud   = sel_w & bus.mem_we & (off == UART_BAUDDIV);
  assign push      = wr_txdata & (~fifo_full | pop);
  assign bus.sel   = sel_w;
  assign unused_ok = &{1'b0, bus.mem_wdata[31:16]};

  always_comb begin
    status_w = '0;
    status_w[ST_FULL]  = fifo_full;
    status_w[ST_EMPTY] = fifo_empty;
    status_w[ST_BUSY]  = busy;
    status_w[ST_OVF]   = ovf_q;
    status_w[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
  end

  always_comb begin
    bus.mem_rdata = '0;
    if (sel_w && bus.mem_re) begin
      case (off)
        UART_STATUS:  bus.mem_rdata = status_w;
        UART_BAUDDIV: bus.mem_rdata = {16'b0, baud_q};
        default:      bus.mem_rdata = '0;
      endcase
    end
  end

  // A STATUS write takes priority, so a coinciding dropped push leaves ovf clear.
  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (wr_baud) baud_d = (bus.mem_wdata[15:0] == 16'd0) ? 16'd1 : bus.mem_wdata[15:0];
    if (wr_txdata && fifo_full && !pop) ovf_d = 1'b1;
    if (wr_status) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q <= 16'(DEFAULT_DIV);
      ovf_q  <= 1'b0;
    end else begin
      baud_q <= baud_d;
      ovf_q  <= ovf_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.mem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- transmit FSM ----------------
  uart_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;     // cycles left in current bit, counts down to 0
  logic [15:0] fdiv_q, fdiv_d;   // divider frozen for the whole frame
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fdiv_q  <= 16'(DEFAULT_DIV);
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fdiv_q  <= fdiv_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fdiv_d  = fdiv_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          fdiv_d  = baud_q;
          cnt_d   = baud_q - 16'd1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = fdiv_q - 16'd1;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = fdiv_q - 16'd1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line trails the FSM by
  // one cycle; this gives the store-to-start-bit latency of two edges.
  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    busy = (state_q != IDLE);
    irq  = fifo_empty & (state_q == IDLE);
  end

  assign tx          = tx_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx, irq;
  uart_state_t state_dbg;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .bus         (bus_if),
    .tx          (tx),
    .irq         (irq),
    .state_dbg_o (state_dbg)
  );

  // ---------------- checker / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Store presented at the current negedge, taken at the next rising edge.
  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    bus_if.mem_addr  = BASE | 32'(off);
    bus_if.mem_wdata = data;
    bus_if.mem_we    = 1'b1;
    @(negedge clk);
    bus_if.mem_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    bus_if.mem_addr = BASE | 32'(off);
    bus_if.mem_re   = 1'b1;
    #1;
    data = bus_if.mem_rdata;
    bus_if.mem_re   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(off, d);
    check(tag, d, exp);
  endtask

  // Wait for a start bit, then check every cycle of the 10-bit frame.
  task automatic monitor_frame(input string tag, input logic [7:0] b, input int div,
                               output int waited);
    logic [9:0] pat;
    logic       obs;
    pat    = {1'b1, b, 1'b0};
    waited = 0;
    while (tx !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check({tag, " start timeout"}, 32'(tx), 32'd0);
      return;
    end
    for (int i = 0; i < 10; i++) begin
      obs = pat[i];
      for (int c = 0; c < div; c++) begin
        if (tx !== pat[i]) obs = tx;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", tag, i), 32'(obs), 32'(pat[i]));
    end
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      if (tx !== 1'b1) lows++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w, lows, g;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_re    = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("reset tx", 32'(tx), 32'd1);
    check("reset irq", 32'(irq), 32'd1);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(50);

    // Idle register state and decode
    check("idle tx", 32'(tx), 32'd1);
    check("idle irq", 32'(irq), 32'd1);
    read_check("idle status", UART_STATUS, 32'h0000_0002);
    read_check("idle bauddiv", UART_BAUDDIV, 32'd16);
    read_check("txdata reads 0", UART_TXDATA, 32'd0);
    bus_write(4'hC, 32'hFFFF_FFFF);
    read_check("reserved reads 0", 4'hC, 32'd0);
    bus_if.mem_addr = BASE + 32'd4;
    #1 check("sel in window", 32'(bus_if.sel), 32'd1);
    check("rdata without re", bus_if.mem_rdata, 32'd0);
    bus_if.mem_addr = 32'h2000_0004;
    bus_if.mem_re   = 1'b1;
    #1 check("sel outside", 32'(bus_if.sel), 32'd0);
    check("rdata outside", bus_if.mem_rdata, 32'd0);
    bus_if.mem_re   = 1'b0;
    @(negedge clk);

    // Single frame 0xA5 at div 4
    bus_write(UART_BAUDDIV, 32'd4);
    read_check("bauddiv 4", UART_BAUDDIV, 32'd4);
    bus_write(UART_TXDATA, 32'hA5);
    fork
      monitor_frame("a5", 8'hA5, 4, w);
      begin
        wait_cycles(12);
        read_check("a5 status busy", UART_STATUS, 32'h0000_0006);
        check("a5 irq low", 32'(irq), 32'd0);
      end
    join
    check("a5 latency", 32'(w), 32'd2);
    wait_cycles(2);
    read_check("a5 status after", UART_STATUS, 32'h0000_0002);

    // Ten back-to-back stores: nine accepted, tenth overflows
    bus_write(UART_BAUDDIV, 32'd16);
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(UART_TXDATA, 32'h30 + 32'(i));
        read_check("ovf status", UART_STATUS, 32'h0000_008D);
        bus_write(UART_STATUS, 32'd0);
        read_check("ovf cleared", UART_STATUS, 32'h0000_0085);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          monitor_frame($sformatf("burst%0d", i), 8'h30 + 8'(i), 16, w);
          if (i > 0) check($sformatf("burst%0d gap", i), 32'(w), 32'd1);
        end
      end
    join
    count_low(60, lows);
    check("no tenth byte", 32'(lows), 32'd0);
    read_check("burst drained", UART_STATUS, 32'h0000_0002);

    // Push on the exact IDLE pop cycle with the FIFO full
    bus_write(UART_BAUDDIV, 32'd4);
    for (int i = 0; i < 9; i++) bus_write(UART_TXDATA, 32'h40 + 32'(i));
    read_check("full status", UART_STATUS, 32'h0000_0085);
    g = 0;
    while (state_dbg != IDLE && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("idle pop reached", 32'(state_dbg), 32'(IDLE));
    bus_write(UART_TXDATA, 32'h77);
    read_check("simul push status", UART_STATUS, 32'h0000_0085);
    g = 0;
    while (irq !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("simul drained irq", 32'(irq), 32'd1);
    read_check("simul drained status", UART_STATUS, 32'h0000_0002);

    // Reset in the middle of data bit 3
    bus_write(UART_TXDATA, 32'h00);
    bus_write(UART_TXDATA, 32'h55);
    bus_write(UART_TXDATA, 32'h55);
    g = 0;
    while (tx !== 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    wait_cycles(18);
    check("pre-reset tx low", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset tx", 32'(tx), 32'd1);
    check("async reset irq", 32'(irq), 32'd1);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    read_check("post-reset status", UART_STATUS, 32'h0000_0002);
    read_check("post-reset bauddiv", UART_BAUDDIV, 32'd16);
    @(negedge clk);
    count_low(200, lows);
    check("no residual bytes", 32'(lows), 32'd0);

    // BAUDDIV of 0 is stored as 1: ten-cycle frames
    bus_write(UART_BAUDDIV, 32'd0);
    read_check("bauddiv zero->1", UART_BAUDDIV, 32'd1);
    bus_write(UART_TXDATA, 32'h3C);
    bus_write(UART_TXDATA, 32'hC3);
    monitor_frame("div1 a", 8'h3C, 1, w);
    monitor_frame("div1 b", 8'hC3, 1, w);
    check("div1 gap", 32'(w), 32'd1);
    wait_cycles(5);

    // Divider change during a frame applies to the next frame only
    bus_write(UART_BAUDDIV, 32'd4);
    bus_write(UART_TXDATA, 32'h11);
    bus_write(UART_TXDATA, 32'h22);
    fork
      begin
        monitor_frame("olddiv", 8'h11, 4, w);
        monitor_frame("newdiv", 8'h22, 8, w);
        check("newdiv gap", 32'(w), 32'd1);
      end
      begin
        wait_cycles(10);
        bus_write(UART_BAUDDIV, 32'd8);
      end
    join
    wait_cycles(3);
    read_check("final bauddiv", UART_BAUDDIV, 32'd8);
    read_check("final status", UART_STATUS, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the sccpu data-memory bus, downstream of the core's store path. The core's single-cycle loads and stores hit three word registers at BASE_ADDR. Written bytes queue in a small FIFO and are serialised 8N1 on tx, LSB first. The block gives the CPU bench a console output path and a serial waveform to check.

Parameters:
BASE_ADDR, 32'h1000_0000, word-aligned base of the 16-byte register window
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
DEFAULT_DIV, 16, clock cycles per serial bit after reset

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
mem_addr  in  32  byte address from the core
mem_wdata  in  32  store data
mem_we  in  1  store strobe, one cycle per store
mem_re  in  1  load strobe
sel  out  1  combinational: mem_addr[31:4] == BASE_ADDR[31:4]
mem_rdata  out  32  combinational read data; 0 when !sel or !mem_re
tx  out  1  serial line; idles high
irq  out  1  high while the FIFO is empty and the FSM is IDLE

Behaviour:
- Register map, offset = mem_addr[3:0]; only word accesses are decoded:
  - 0x0 TXDATA: write pushes mem_wdata[7:0]; reads 0.
  - 0x4 STATUS: read gives {22'b0, count[5:0], ovf, busy, empty, full}. Any write clears ovf.
  - 0x8 BAUDDIV: read/write bits [15:0]. A written 0 is stored as 1.
  - 0xC: reserved; reads 0, writes ignored.
- Reset (rst=0, asynchronous):
  - FIFO emptied; read and write pointers and count set to 0.
  - ovf=0; FSM to IDLE; BAUDDIV=DEFAULT_DIV.
  - tx=1 immediately, including when reset lands mid-frame.
  - irq=1 once reset is applied.
- Push on sel & mem_we & offset 0x0:
  - Accepted if !full, or if a pop happens in the same cycle. In the simultaneous case count is unchanged.
  - If full and no pop: byte dropped, ovf set (sticky). If a push and a STATUS write coincide, ovf ends up cleared.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0).
  - A byte pushed into an empty FIFO becomes visible to the FSM the following cycle. No same-cycle bypass.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If !empty: pop the head into the shift register, latch BAUDDIV into the frame divider, load the bit counter with div-1, go to START.
  - START: tx=0 for div cycles. Then go to DATA with bit index 0.
  - DATA: tx=shift[0] for div cycles per bit; shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for div cycles. Then back to IDLE.
  - busy = (state != IDLE).
  - A frame is exactly 10*div cycles. Back-to-back frames have one IDLE cycle between STOP and the next START.
- Divider: a BAUDDIV write during a frame does not affect that frame; it applies from the next frame's latch.
- Latency: a push to an empty, idle FIFO drives tx low at edge N+2, where the store is at edge N.
- Loads have no side effects.

Decomposition:
- Shared package (def.sv):
  - Register offsets UART_TXDATA=4'h0, UART_STATUS=4'h4, UART_BAUDDIV=4'h8.
  - STATUS bit positions.
  - Enum typedef uart_state_t {IDLE, START, DATA, STOP}.
- One sub-module, sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same clk/rst scheme.
- The FSM and register decode stay in mmio_uart_tx.

Test Plan:
- Reset then idle 50 cycles -> tx=1, STATUS reads 32'h0000_0002, BAUDDIV reads 16, irq=1.
- BAUDDIV=4, store 8'hA5 to TXDATA -> tx low two edges later for 4 cycles; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; total 40 cycles; busy high throughout.
- 10 back-to-back stores 0x30..0x39 with FIFO_DEPTH=8 and div=16:
  - First byte is popped before the ninth store arrives, so 9 are accepted and the 10th is dropped.
  - ovf=1, full=1 seen in STATUS.
  - Serial output 0x30..0x38.
  - A STATUS write then clears ovf.
- Push on the exact cycle IDLE pops with FIFO full -> push accepted, count stays 8, no ovf.
- rst asserted mid-DATA bit 3 -> tx=1 asynchronously; after release STATUS=32'h2 and no residual bytes are transmitted.
- BAUDDIV written to 0 -> reads back 1, next frame lasts 10 cycles. BAUDDIV=8 written mid-frame -> current frame keeps its old divider, next frame is 80 cycles.
